// File: rtl/kpn_pkg.sv
// rtl/kpn_pkg.sv - shared types and encodings for KPN process nodes
package kpn_pkg;

  typedef enum logic [1:0] {
    READ    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/kpn_adder_process_if.sv
// rtl/kpn_adder_process_if.sv - token channel bundle for the adder process node
interface kpn_adder_process_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
);

  logic                 mode;
  logic [WIDTH-1:0]     entry_1;
  logic [WIDTH-1:0]     entry_2;
  logic                 empty_1;
  logic                 empty_2;
  logic                 rd;
  logic                 full;
  logic                 wr;
  logic [WIDTH-1:0]     output_1;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] op_count;

  modport master (
    output mode, entry_1, entry_2, empty_1, empty_2, full,
    input  rd, wr, output_1, overflow, op_count
  );

  modport slave (
    input  mode, entry_1, entry_2, empty_1, empty_2, full,
    output rd, wr, output_1, overflow, op_count
  );

endinterface

// File: rtl/kpn_arith_unit.sv
// rtl/kpn_arith_unit.sv - combinational unsigned add/sub with optional saturation
module kpn_arith_unit
  import kpn_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             flag_o
);

  logic [WIDTH:0] ext;

  // The extra MSB is the carry for add and the borrow for sub.
  always_comb begin
    ext      = '0;
    result_o = '0;
    flag_o   = 1'b0;
    case (op_i)
      MODE_ADD: ext = {1'b0, a_i} + {1'b0, b_i};
      MODE_SUB: ext = {1'b0, a_i} - {1'b0, b_i};
    endcase
    flag_o   = ext[WIDTH];
    result_o = ext[WIDTH-1:0];
    if (SATURATE && flag_o) begin
      result_o = (op_i == MODE_ADD) ? '1 : '0;
    end
  end

endmodule

// File: rtl/kpn_adder_process.sv
// rtl/kpn_adder_process.sv - Kahn-process adder/subtractor node with FIFO handshake
module kpn_adder_process
  import kpn_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SATURATE  = 1'b0,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  kpn_adder_process_if.slave bus
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     output_q, output_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 rd, wr;
  logic [WIDTH-1:0]     arith_result;
  logic                 arith_flag;

  kpn_arith_unit #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_arith (
    .op_i     (bus.mode),
    .a_i      (bus.entry_1),
    .b_i      (bus.entry_2),
    .result_o (arith_result),
    .flag_o   (arith_flag)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= READ;
      output_q   <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      output_q   <= output_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  // Strobes are gated by reset_n so nothing pops or pushes while reset is held.
  always_comb begin
    state_d    = state_q;
    output_d   = output_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    rd         = 1'b0;
    wr         = 1'b0;
    case (state_q)
      READ: begin
        rd = reset_n && !bus.empty_1 && !bus.empty_2;
        if (rd) state_d = CAPTURE;
      end
      CAPTURE: begin
        output_d   = arith_result;
        overflow_d = overflow_q | arith_flag;
        state_d    = WRITE;
      end
      WRITE: begin
        wr = reset_n && !bus.full;
        if (wr) begin
          count_d = count_q + 1'b1;
          state_d = READ;
        end
      end
      default: state_d = READ;
    endcase
  end

  assign bus.rd       = rd;
  assign bus.wr       = wr;
  assign bus.output_1 = output_q;
  assign bus.overflow = overflow_q;
  assign bus.op_count = count_q;

endmodule

// File: tb/tb_kpn_adder_process.sv
// tb/tb_kpn_adder_process.sv - self-checking bench for kpn_adder_process
module tb_kpn_adder_process;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          m;
  } tok_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode;
  logic [15:0] entry_1, entry_2;
  logic        empty_1, empty_2, full;

  always #5 clk = ~clk;

  kpn_adder_process_if #(.WIDTH(16), .CNT_WIDTH(16)) bus0 ();
  kpn_adder_process_if #(.WIDTH(16), .CNT_WIDTH(16)) bus1 ();

  assign bus0.mode = mode;  assign bus1.mode = mode;
  assign bus0.entry_1 = entry_1;  assign bus1.entry_1 = entry_1;
  assign bus0.entry_2 = entry_2;  assign bus1.entry_2 = entry_2;
  assign bus0.empty_1 = empty_1;  assign bus1.empty_1 = empty_1;
  assign bus0.empty_2 = empty_2;  assign bus1.empty_2 = empty_2;
  assign bus0.full = full;  assign bus1.full = full;

  kpn_adder_process #(.WIDTH(16), .SATURATE(1'b0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  kpn_adder_process #(.WIDTH(16), .SATURATE(1'b1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  int checks = 0, errors = 0;
  int pushed = 0, pops = 0, cyc = 0, rd_cyc = 0, wr_cyc = 0;
  bit ovf_model = 0, cap_pending = 0, full_req = 0, hold_e1 = 0, hold_e2 = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  bit          qm[$];
  tok_t        infl[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; bit 16 is the carry/borrow.
  function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input bit m, input bit sat);
    int r;
    bit ov;
    r  = m ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    ov = (r > 65535) || (r < 0);
    if (sat && r > 65535) r = 65535;
    else if (sat && r < 0) r = 0;
    else if (r < 0) r = r + 65536;
    else if (r > 65535) r = r - 65536;
    return {ov, r[15:0]};
  endfunction

  task automatic push_tok(input logic [15:0] a, input logic [15:0] b, input bit m);
    q1.push_back(a);
    q2.push_back(b);
    qm.push_back(m);
  endtask

  task automatic tick();
    logic        rd_s, wr_s;
    tok_t        t;
    logic [16:0] r0, r1;
    @(negedge clk);
    rd_s = bus0.rd;
    wr_s = bus0.wr;
    check("rd_sat_match", 32'(bus1.rd), 32'(rd_s));
    check("wr_sat_match", 32'(bus1.wr), 32'(wr_s));
    check("op_count", 32'(bus0.op_count), pushed & 32'hFFFF);
    check("op_count_sat", 32'(bus1.op_count), pushed & 32'hFFFF);
    check("overflow", 32'(bus0.overflow), 32'(ovf_model));
    check("overflow_sat", 32'(bus1.overflow), 32'(ovf_model));
    if (rd_s) begin
      check("rd_guard", 32'(empty_1 | empty_2), 32'd0);
      rd_cyc = cyc;
    end
    if (wr_s) begin
      check("wr_guard", 32'(full), 32'd0);
      check("wr_token", 32'(infl.size()), 32'd1);
      if (infl.size() != 0) begin
        t  = infl.pop_front();
        r0 = ref_op(t.a, t.b, t.m, 1'b0);
        r1 = ref_op(t.a, t.b, t.m, 1'b1);
        check("out_wrap", 32'(bus0.output_1), 32'(r0[15:0]));
        check("out_sat", 32'(bus1.output_1), 32'(r1[15:0]));
      end
      wr_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (wr_s) pushed++;
    if (cap_pending && infl.size() != 0) begin
      t  = infl[$];
      r0 = ref_op(t.a, t.b, t.m, 1'b0);
      ovf_model = ovf_model | r0[16];
    end
    cap_pending = 0;
    if (rd_s) begin
      check("pop_src", 32'(q1.size() > 0 && q2.size() > 0), 32'd1);
      if (q1.size() > 0 && q2.size() > 0) begin
        t.a = q1.pop_front();
        t.b = q2.pop_front();
        t.m = qm.pop_front();
        entry_1 = t.a;
        entry_2 = t.b;
        mode    = t.m;
        infl.push_back(t);
        cap_pending = 1;
        pops++;
      end
    end else begin
      mode = 1'($urandom);
    end
    empty_1 = (q1.size() == 0) || hold_e1;
    empty_2 = (q2.size() == 0) || hold_e2;
    full    = full_req;
  endtask

  task automatic run_until(input int n, input int budget);
    int b = budget;
    while (pushed < n && b > 0) begin
      tick();
      b--;
    end
    check("drain", pushed, n);
  endtask

  task automatic wait_write(input int budget);
    int b = budget;
    while (!(infl.size() == 1 && !cap_pending) && b > 0) begin
      tick();
      b--;
    end
    check("reach_write", 32'(infl.size() == 1 && !cap_pending), 32'd1);
  endtask

  initial begin
    int          p0, base, guard;
    logic [16:0] e;
    reset_n = 1'b0;
    mode    = 1'b0;
    entry_1 = '0;
    entry_2 = '0;
    empty_1 = 1'b1;
    empty_2 = 1'b1;
    full    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd", 32'(bus0.rd), 32'd0);
    check("rst_wr", 32'(bus0.wr), 32'd0);
    check("rst_out", 32'(bus0.output_1), 32'd0);
    check("rst_ovf", 32'(bus0.overflow), 32'd0);
    check("rst_cnt", 32'(bus0.op_count), 32'd0);
    reset_n = 1'b1;

    push_tok(16'd3, 16'd4, 1'b0);
    run_until(1, 20);
    check("lat_rd_wr", wr_cyc - rd_cyc, 32'd2);

    push_tok(16'hFFFF, 16'h0002, 1'b0);
    push_tok(16'd5, 16'd9, 1'b1);
    run_until(3, 40);

    hold_e2 = 1;
    push_tok(16'h1234, 16'h0101, 1'b0);
    tick();
    p0 = pops;
    repeat (10) tick();
    check("empty2_block", pops, p0);
    hold_e2 = 0;
    tick();
    tick();
    check("empty2_release", pops, p0 + 1);
    check("q1_consumed", 32'(q1.size()), 32'd0);
    check("q2_consumed", 32'(q2.size()), 32'd0);
    run_until(4, 20);

    full_req = 1;
    push_tok(16'd100, 16'd23, 1'b1);
    wait_write(20);
    e = ref_op(16'd100, 16'd23, 1'b1, 1'b0);
    repeat (5) begin
      tick();
      check("hold_wr", 32'(bus0.wr), 32'd0);
      check("hold_out", 32'(bus0.output_1), 32'(e[15:0]));
    end
    full_req = 0;
    tick();
    tick();
    check("full_release", pushed, 5);
    run_until(5, 5);

    full_req = 1;
    push_tok(16'd7, 16'd8, 1'b0);
    wait_write(20);
    push_tok(16'd9, 16'd9, 1'b0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rd", 32'(bus0.rd), 32'd0);
    check("mid_rst_wr", 32'(bus0.wr), 32'd0);
    check("mid_rst_out", 32'(bus0.output_1), 32'd0);
    check("mid_rst_out_sat", 32'(bus1.output_1), 32'd0);
    check("mid_rst_cnt", 32'(bus0.op_count), 32'd0);
    check("mid_rst_ovf", 32'(bus0.overflow), 32'd0);
    q1.delete();
    q2.delete();
    qm.delete();
    infl.delete();
    cap_pending = 0;
    pushed      = 0;
    ovf_model   = 0;
    full_req    = 0;
    full        = 1'b0;
    empty_1     = 1'b1;
    empty_2     = 1'b1;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) push_tok(16'($urandom_range(0, 1000)), 16'($urandom_range(0, 1000)), 1'b0);
    run_until(4, 60);
    check("stream4_cnt", 32'(bus0.op_count), 32'd4);

    base = pushed;
    for (int i = 0; i < 40; i++) push_tok(16'($urandom), 16'($urandom), 1'($urandom));
    guard = 0;
    while (pushed < base + 40 && guard < 3000) begin
      full_req = ($urandom_range(0, 2) == 0);
      hold_e1  = ($urandom_range(0, 4) == 0);
      hold_e2  = ($urandom_range(0, 4) == 0);
      tick();
      guard++;
    end
    hold_e1  = 0;
    hold_e2  = 0;
    full_req = 0;
    check("random_done", pushed, base + 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
